// File: rtl/alu_seq_nbit_if.sv
// Operand/result bundle for alu_seq_nbit: start handshake, operands, result and flags.
interface alu_seq_nbit_if #(parameter int WIDTH = 32);
   logic             start;
   logic [2:0]       Aluop;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] R;
   logic [WIDTH-1:0] R_hi;
   logic             cout;
   logic             V;
   logic             S;

   modport master (output start, Aluop, a, b, cin,
                   input  busy, done, R, R_hi, cout, V, S);
   modport slave  (input  start, Aluop, a, b, cin,
                   output busy, done, R, R_hi, cout, V, S);
endinterface

// File: rtl/alu_seq_nbit.sv
// Registered WIDTH-bit ALU with start/busy/done handshake; shift-add multiplier
// is built only when ALU_MULT_EN is defined, otherwise opcode 110 returns zeros.
module alu_seq_nbit #(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_seq_nbit_if.slave bus
);
   localparam int M  = WIDTH - 1;
   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [2:0] OP_AND = 3'b000, OP_OR  = 3'b001, OP_XOR = 3'b010,
                          OP_ADD = 3'b011, OP_SLT = 3'b100, OP_SUB = 3'b101,
                          OP_MUL = 3'b110, OP_NOR = 3'b111;

   logic [WIDTH-1:0] r_q, rhi_q;
   logic             cout_q, v_q, s_q, done_q;
   logic             busy, sc_go;

   logic [WIDTH:0]   add_sum, sub_sum;
   logic             add_v, sub_v;
   logic [WIDTH-1:0] sc_r;
   logic             sc_cout, sc_v;

   assign add_sum = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
   assign sub_sum = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
   assign add_v   = (bus.a[M] == bus.b[M]) && (add_sum[M] != bus.a[M]);
   assign sub_v   = (bus.a[M] != bus.b[M]) && (sub_sum[M] != bus.a[M]);

   always_comb begin
      sc_r    = '0;
      sc_cout = 1'b0;
      sc_v    = 1'b0;
      case (bus.Aluop)
         OP_AND: sc_r = bus.a & bus.b;
         OP_OR:  sc_r = bus.a | bus.b;
         OP_XOR: sc_r = bus.a ^ bus.b;
         OP_NOR: sc_r = ~(bus.a | bus.b);
         OP_ADD: begin
            sc_r    = add_sum[M:0];
            sc_cout = add_sum[WIDTH];
            sc_v    = add_v;
         end
         // Sign of the difference corrected by overflow gives signed a<b.
         OP_SLT: begin
            sc_r    = {{(WIDTH-1){1'b0}}, sub_sum[M] ^ sub_v};
            sc_cout = sub_sum[WIDTH];
            sc_v    = sub_v;
         end
         OP_SUB: begin
            sc_r    = sub_sum[M:0];
            sc_cout = sub_sum[WIDTH];
            sc_v    = sub_v;
         end
         default: sc_r = '0;
      endcase
   end

`ifdef ALU_MULT_EN
   typedef enum logic {IDLE, MUL} state_t;
   state_t           state, nstate;
   logic [WIDTH-1:0] mcand, mplier, acc;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   step;
   logic             mul_go, mul_last;

   // Product forms in {acc, mplier}: multiplier bits shift out the bottom
   // while accumulated partial sums shift in from the top.
   assign step     = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
   assign busy     = (state == MUL);
   assign mul_go   = (state == IDLE) && bus.start && (bus.Aluop == OP_MUL);
   assign mul_last = busy && (cnt == CW'(WIDTH - 1));
   assign sc_go    = bus.start && !busy && (bus.Aluop != OP_MUL);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= nstate;

   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (mul_go)   nstate = MUL;
         MUL:     if (mul_last) nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else if (mul_go) begin
         mcand  <= bus.a;
         mplier <= bus.b;
         acc    <= '0;
         cnt    <= '0;
      end else if (busy) begin
         cnt           <= cnt + CW'(1);
         {acc, mplier} <= {step, mplier[M:1]};
      end
`else
   assign busy  = 1'b0;
   assign sc_go = bus.start;
`endif

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_q    <= '0;
         rhi_q  <= '0;
         cout_q <= 1'b0;
         v_q    <= 1'b0;
         s_q    <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
`ifdef ALU_MULT_EN
         if (mul_last) begin
            r_q    <= {step[0], mplier[M:1]};
            rhi_q  <= step[WIDTH:1];
            cout_q <= 1'b0;
            v_q    <= |step[WIDTH:1];
            s_q    <= step[WIDTH];
            done_q <= 1'b1;
         end else
`endif
         if (sc_go) begin
            r_q    <= sc_r;
            rhi_q  <= '0;
            cout_q <= sc_cout;
            v_q    <= sc_v;
            s_q    <= sc_r[M];
            done_q <= 1'b1;
         end
      end

   assign bus.busy = busy;
   assign bus.done = done_q;
   assign bus.R    = r_q;
   assign bus.R_hi = rhi_q;
   assign bus.cout = cout_q;
   assign bus.V    = v_q;
   assign bus.S    = s_q;
endmodule

// File: doc/alu_seq_nbit.md
# alu_seq_nbit

Parametrised, registered successor to the 32-bit combinational ALU: same 3-bit opcode space (SLT at 3'b100) and cin/cout/S/V flag set, generalised to WIDTH bits and wrapped in a start/busy/done handshake. Single-cycle ops register their result one clock after acceptance. Multiply is a WIDTH-cycle shift-add sequence producing a 2·WIDTH unsigned product. Sits between the register-file read stage and the writeback mux of the datapath.

## Interface
- WIDTH, 32, operand/result width in bits, ≥ 4

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; accepted only when busy=0
- Aluop  input  3  operation select, sampled with start
- a  input  WIDTH  operand A, sampled with start
- b  input  WIDTH  operand B, sampled with start
- cin  input  1  carry-in, used by ADD only
- busy  output  1  multiply in progress
- done  output  1  one-cycle pulse: R/R_hi/flags valid
- R  output  WIDTH  result (low half of product for MULT)
- R_hi  output  WIDTH  high half of product; 0 for other ops
- cout  output  1  carry out
- V  output  1  overflow
- S  output  1  sign (MSB of R; MSB of R_hi for MULT)

## Operation
- Opcodes: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SLT, 101 SUB, 110 MULT, 111 NOR.
- ADD: R = a+b+cin; cout = carry out of MSB; V = signed overflow; S = R[WIDTH-1].
- SUB: R = a+~b+1, cin ignored; cout = carry out (1 = no borrow); V = signed overflow.
- SLT: signed compare; R = {0…, (a−b)[MSB] ^ V_sub}; cout and V reflect the internal subtraction; S = 0.
- AND/OR/XOR/NOR: bitwise; cout=0, V=0, S=R[MSB].
- MULT: unsigned {R_hi,R} = a·b; cout=0; V = |R_hi; S = R_hi[MSB].
- FSM: IDLE, MUL. IDLE+start+MULT → MUL (operands latched into multiplicand/multiplier registers, accumulator cleared, counter=0). MUL: one add-and-shift per cycle; after iteration WIDTH → IDLE, load outputs, pulse done.
- Non-MULT start in IDLE: result computed from the sampled inputs and registered at the accepting edge; FSM stays IDLE.
- Outputs hold their last value until the next done; R_hi=0 for every non-MULT result.
- start while busy=1: ignored, no side effects. a/b/Aluop/cin changes during busy have no effect.

## Timing
- Reset (async, immediate): R=0, R_hi=0, cout=0, V=0, S=0, busy=0, done=0, FSM=IDLE, counter=0. Reset mid-multiply aborts; no done is produced.
- Single-cycle ops: start sampled at edge k → done=1 and result valid for cycle k..k+1; done low after edge k+1 unless another op completes there.
- MULT: start at edge k → busy=1 from k; iterations on edges k+1…k+WIDTH; at edge k+WIDTH busy=0, done=1, result valid. Latency WIDTH cycles.
- Back-to-back: start is legal in the cycle done=1 (busy=0); a new single-cycle op produces done on consecutive cycles.
- Counter width clog2(WIDTH)+1; no wrap within an operation.

## Configuration
- ALU_MULT_EN defined: MULT implemented as above.
- ALU_MULT_EN undefined: no multiplier registers or MUL state; opcode 110 completes as a single-cycle op with R=0, R_hi=0, cout=0, V=0, S=0; busy is tied 0.

## Test plan
- WIDTH=32, SLT: a=0x0000000B, b=0x000FF005 → R=1; a=0x38404F07, b=0x03003101 → R=0; done one cycle after start.
- WIDTH=32, ADD: a=0x7FFFFFFF, b=0x00000001, cin=0 → R=0x80000000, V=1, S=1, cout=0; SUB a=0, b=1 → R=0xFFFFFFFF, cout=0, V=0.
- WIDTH=32, MULT (ALU_MULT_EN): a=b=0xFFFFFFFF → R_hi=0xFFFFFFFE, R=0x00000001, V=1, done exactly 32 cycles after start, busy high 32 cycles.
- During MULT, pulse start with Aluop=011 at cycle 5 → ignored; only one done, MULT result unchanged.
- Drop rst_n at cycle 10 of a MULT → all outputs 0 immediately, no done; subsequent ADD 3+4 → R=7 after one cycle.
- WIDTH=8: MULT 0x0F·0x11 → R=0xFF, R_hi=0x00, V=0, done after 8 cycles; without ALU_MULT_EN, same stimulus → R=0, done after 1 cycle.
